xbip_dsp48_macro: RTL and testbench
===================================

XBIP_DSP48_MACRO -- requirements
Module: xbip_dsp48_macro

Interface
REQ-001 Parameter A_W, default 16, multiplicand A width in bits.
REQ-002 Parameter B_W, default 16, multiplier B width in bits.
REQ-003 Parameter P_W, default 48, accumulator/output width; SHALL satisfy P_W >= A_W+B_W.
REQ-004 The block SHALL use one clock and a synchronous, active-low reset.
REQ-005 CLK  input  1  sole clock; all registers update on its rising edge.
REQ-006 RST_N  input  1  synchronous active-low reset.
REQ-007 SCLR  input  1  synchronous active-high accumulator/pipeline clear.
REQ-008 CE  input  1  clock enable for all pipeline registers; active high.
REQ-009 A  input  A_W  unsigned multiplicand (data sample).
REQ-010 B  input  B_W  unsigned multiplier (weight).
REQ-011 P  output  P_W  registered accumulated sum of products.
REQ-012 OVF  output  1  registered sticky accumulator-overflow flag.

Function
REQ-013 Operands SHALL be unsigned; product is A_W+B_W bits, zero-extended to P_W before accumulation.
REQ-014 Pipeline SHALL be three register stages: AREG/BREG capture A,B at edge n; MREG captures AREG*BREG at edge n+1; PREG performs P <= P + MREG at edge n+2.
REQ-015 A product sampled at edge n SHALL first appear in P after edge n+2 and remain included until cleared.
REQ-016 P SHALL be driven directly from PREG; no combinational path from A/B to P.
REQ-017 When CE=0 and SCLR=0, all registers (AREG, BREG, MREG, PREG, OVF) SHALL hold.
REQ-018 When SCLR=1 at an edge, AREG, BREG, MREG, PREG and OVF SHALL all become 0, regardless of CE.
REQ-019 Holding SCLR=1 for multiple cycles SHALL keep P=0; the first edge with SCLR=0, CE=1 samples new operands (P nonzero no earlier than 2 edges later).
REQ-020 SCLR SHALL take priority over CE; RST_N SHALL take priority over SCLR and CE.
REQ-021 OVF SHALL be set at the PREG edge where P + MREG exceeds 2^P_W-1, and stay set until SCLR or reset.
REQ-022 Multiplying by zero on either operand SHALL contribute exactly 0; max operands (all ones) SHALL produce (2^A_W-1)*(2^B_W-1) exactly.

Reset
REQ-023 RST_N=0 at a rising edge SHALL clear AREG, BREG, MREG, PREG to 0 and OVF to 0; P=0, OVF=0 after that edge.
REQ-024 Reset asserted mid-accumulation SHALL discard all in-flight products; no partial result survives.
REQ-025 Register values before the first reset edge are undefined; no asynchronous behaviour is permitted.

Configuration
REQ-026 Macro XBIP_DSP48_SATURATE_EN SHALL select accumulator overflow handling.
REQ-027 With XBIP_DSP48_SATURATE_EN defined: on overflow P SHALL saturate at 2^P_W-1 and hold there on further accumulation; OVF set.
REQ-028 Without it: P SHALL wrap modulo 2^P_W; OVF still set sticky on wrap.

Verification
REQ-029 Reset: RST_N=0 one edge with A=5,B=7,CE=1 -> P=0, OVF=0; release, SCLR=0 -> P=35 after third edge following release.
REQ-030 Accumulate: SCLR deasserted, A=3,B=4 held, CE=1 -> P sequence 0,0,12,24,36,48 on successive edges.
REQ-031 Clear mid-run: after P=48, SCLR=1 one edge with CE=0 -> P=0 next edge; pipeline empty (following two edges with A=0 keep P=0).
REQ-032 Stall: CE=0 for 3 edges while A=9,B=9 -> P, OVF unchanged; CE=1 resumes with no lost or duplicated product.
REQ-033 Overflow: P_W=32, A=B=16'hFFFF continuous -> second product overflows; OVF=1; P=32'hFFFFFFFF with XBIP_DSP48_SATURATE_EN, else P=(2*0xFFFE0001) mod 2^32.
REQ-034 Extremes: A=0,B=16'hFFFF -> adds 0; A=B=16'hFFFF single product at P_W=48 -> P=48'h0000FFFE0001, OVF=0.

Source files
------------

// File: rtl/xbip_dsp48_macro.sv
// rtl/xbip_dsp48_macro.sv - unsigned multiply-accumulate, A/B -> M -> P pipeline
// Define XBIP_DSP48_SATURATE_EN to saturate P on overflow; otherwise P wraps.
module xbip_dsp48_macro #(
  parameter int A_W = 16,
  parameter int B_W = 16,
  parameter int P_W = 48
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sclr,
  input  logic           ce,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [P_W-1:0] p,
  output logic           ovf
);

  localparam int M_W = A_W + B_W;

  logic [A_W-1:0] areg;
  logic [B_W-1:0] breg;
  logic [M_W-1:0] mreg;
  logic [P_W-1:0] preg;
  logic           ovf_q;
  logic [M_W-1:0] prod;
  logic [P_W:0]   sum;
  logic [P_W-1:0] acc_next;

  assign prod = {{B_W{1'b0}}, areg} * {{A_W{1'b0}}, breg};

  // One extra bit on the adder exposes the carry-out that marks overflow.
  assign sum = {1'b0, preg} + {{(P_W + 1 - M_W){1'b0}}, mreg};

`ifdef XBIP_DSP48_SATURATE_EN
  assign acc_next = sum[P_W] ? {P_W{1'b1}} : sum[P_W-1:0];
`else
  assign acc_next = sum[P_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || sclr) begin
      areg  <= '0;
      breg  <= '0;
      mreg  <= '0;
      preg  <= '0;
      ovf_q <= 1'b0;
    end else if (ce) begin
      areg <= a;
      breg <= b;
      mreg <= prod;
      preg <= acc_next;
      if (sum[P_W]) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign p   = preg;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_xbip_dsp48_macro.sv
// tb/tb_xbip_dsp48_macro.sv - directed MAC test with product-queue reference model
// Runs a 48-bit and a 32-bit instance side by side on the same stimulus.
module tb_xbip_dsp48_macro;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sclr = 1'b0;
  logic        ce = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [47:0] p48;
  logic        ovf48;
  logic [31:0] p32;
  logic        ovf32;

  int vectors = 0;
  int miscompares = 0;

`ifdef XBIP_DSP48_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  xbip_dsp48_macro #(.A_W(16), .B_W(16), .P_W(48)) dut48 (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .ce(ce), .a(a), .b(b), .p(p48), .ovf(ovf48)
  );

  xbip_dsp48_macro #(.A_W(16), .B_W(16), .P_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .ce(ce), .a(a), .b(b), .p(p32), .ovf(ovf32)
  );

  always #5 clk = ~clk;

  // Reference: every enabled edge samples a product; it is added to the
  // accumulator on the second enabled edge after it was sampled.
  longint unsigned q[$];
  longint unsigned macc[2];
  longint unsigned mmax[2] = '{64'h0000_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
  bit              movf[2];
  bit              model_valid = 1'b0;

  always @(posedge clk) begin
    longint unsigned prod, sum;
    if (!rst_n || sclr) begin
      q.delete();
      for (int i = 0; i < 2; i++) begin
        macc[i] = 0;
        movf[i] = 1'b0;
      end
      if (!rst_n) model_valid = 1'b1;
    end else if (ce) begin
      q.push_back(64'(a) * 64'(b));
      if (q.size() > 2) begin
        prod = q.pop_front();
        for (int i = 0; i < 2; i++) begin
          sum = macc[i] + prod;
          if (sum > mmax[i]) begin
            movf[i] = 1'b1;
            macc[i] = SAT ? mmax[i] : (sum & mmax[i]);
          end else begin
            macc[i] = sum;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      chk("model_p48", 64'(p48), macc[0]);
      chk("model_ovf48", 64'(ovf48), 64'(movf[0]));
      chk("model_p32", 64'(p32), macc[1]);
      chk("model_ovf32", 64'(ovf32), 64'(movf[1]));
    end
  end

  task automatic step(input logic r, input logic s, input logic e,
                      input logic [15:0] av, input logic [15:0] bv);
    rst_n = r;
    sclr  = s;
    ce    = e;
    a     = av;
    b     = bv;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    longint unsigned acc_exp[6];
    acc_exp = '{0, 0, 12, 24, 36, 48};
    @(negedge clk);

    // Reset with live operands, then release and let 5*7 reach P.
    step(1'b0, 1'b0, 1'b1, 16'd5, 16'd7);
    chk("rst_p", 64'(p48), 0);
    chk("rst_ovf", 64'(ovf48), 0);
    repeat (2) step(1'b1, 1'b0, 1'b1, 16'd5, 16'd7);
    chk("rel_p_2edges", 64'(p48), 0);
    step(1'b1, 1'b0, 1'b1, 16'd5, 16'd7);
    chk("rel_p_35", 64'(p48), 35);

    // Steady accumulation of 3*4 from an empty pipeline.
    step(1'b1, 1'b1, 1'b0, 16'd0, 16'd0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b1, 16'd3, 16'd4);
      chk($sformatf("acc_seq%0d", i), 64'(p48), acc_exp[i]);
    end

    // Clear with CE low, then confirm nothing was left in flight.
    step(1'b1, 1'b1, 1'b0, 16'd3, 16'd4);
    chk("clr_p", 64'(p48), 0);
    repeat (2) step(1'b1, 1'b0, 1'b1, 16'd0, 16'd4);
    chk("clr_empty", 64'(p48), 0);

    // Stall: two 2*5 products in flight, three held edges, then 1*1 stream.
    repeat (2) step(1'b1, 1'b0, 1'b1, 16'd2, 16'd5);
    repeat (3) step(1'b1, 1'b0, 1'b0, 16'd9, 16'd9);
    chk("stall_hold", 64'(p48), 0);
    step(1'b1, 1'b0, 1'b1, 16'd1, 16'd1);
    chk("stall_resume1", 64'(p48), 10);
    step(1'b1, 1'b0, 1'b1, 16'd1, 16'd1);
    chk("stall_resume2", 64'(p48), 20);
    repeat (2) step(1'b1, 1'b0, 1'b1, 16'd1, 16'd1);
    chk("stall_resume4", 64'(p48), 22);

    // Extremes: zero operand, then a single all-ones product.
    step(1'b1, 1'b1, 1'b1, 16'd0, 16'd0);
    repeat (3) step(1'b1, 1'b0, 1'b1, 16'd0, 16'hFFFF);
    chk("zero_op", 64'(p48), 0);
    step(1'b1, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
    repeat (3) step(1'b1, 1'b0, 1'b1, 16'd0, 16'hFFFF);
    chk("max_p48", 64'(p48), 64'h0000_FFFE_0001);
    chk("max_ovf48", 64'(ovf48), 0);
    chk("max_p32", 64'(p32), 64'hFFFE_0001);

    // Overflow of the 32-bit accumulator on the second all-ones product.
    step(1'b1, 1'b1, 1'b0, 16'd0, 16'd0);
    repeat (3) step(1'b1, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
    chk("ovf_first_ovf32", 64'(ovf32), 0);
    step(1'b1, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
    chk("ovf_ovf32", 64'(ovf32), 1);
    chk("ovf_p32", 64'(p32), SAT ? 64'hFFFF_FFFF : 64'hFFFC_0002);
    chk("ovf_p48", 64'(p48), 64'h1_FFFC_0002);
    chk("ovf_ovf48", 64'(ovf48), 0);
    step(1'b1, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
    chk("ovf_sticky", 64'(ovf32), 1);

    // Reset mid-accumulation discards everything in flight.
    step(1'b0, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
    repeat (3) step(1'b1, 1'b0, 1'b1, 16'd0, 16'd0);
    chk("midrst_p", 64'(p48), 0);
    chk("midrst_ovf32", 64'(ovf32), 0);

    // Held clear keeps P at zero; first free edge samples new operands.
    repeat (2) step(1'b1, 1'b0, 1'b1, 16'd6, 16'd7);
    repeat (3) step(1'b1, 1'b1, 1'b1, 16'd6, 16'd7);
    chk("sclr_hold", 64'(p48), 0);
    repeat (2) step(1'b1, 1'b0, 1'b1, 16'd6, 16'd7);
    chk("sclr_rel2", 64'(p48), 0);
    step(1'b1, 1'b0, 1'b1, 16'd6, 16'd7);
    chk("sclr_rel3", 64'(p48), 42);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
